// File: rtl/timer_ctrl.sv
// timer_ctrl: sequences the BCD digit-counter chain (prescale, load, run, pause, done).
module timer_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned TICK_W     = 27
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    clear,
  input  logic                    mode_up,
  input  logic [4*NUM_DIGITS-1:0] preset_val,
  input  logic [4*NUM_DIGITS-1:0] cnt_value,
  output logic                    cnt_rst,
  output logic                    cnt_load,
  output logic [4*NUM_DIGITS-1:0] cnt_load_val,
  output logic                    cnt_en,
  output logic                    cnt_up,
  output logic [2:0]              state,
  output logic                    running,
  output logic                    done,
  output logic                    alarm
);

  localparam int unsigned         VAL_W     = 4 * NUM_DIGITS;
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  presc_q, presc_d;
  logic [VAL_W-1:0]   preset_q, preset_d;
  logic               up_q, up_d;
  logic               run_en;
  logic               at_term;
  logic               en_d, rst_d, load_d, running_d, done_d, alarm_d;
  logic [VAL_W-1:0]   load_val_d;

  assign state  = state_q;
  assign cnt_up = up_q;

  // Release synchroniser: the FSM ignores the first edge after reset deassertion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run_en <= 1'b0;
    else        run_en <= 1'b1;
  end

  // Terminal value: zero when counting down, the latched preset when counting up.
  always_comb begin
    at_term = (cnt_value == (up_q ? preset_q : '0));
  end

  // Next state, prescaler, command handling and next values of the registered outputs.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    preset_d = preset_q;
    up_d     = up_q;
    en_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d = '0;
        if (start) begin
          state_d  = S_LOAD;
          preset_d = preset_val;
          up_d     = mode_up;
        end
      end
      S_LOAD: begin
        presc_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (start) begin
          state_d  = S_LOAD;
          preset_d = preset_val;
          up_d     = mode_up;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (at_term) begin
          state_d = S_DONE;
        end else if (presc_q == TICK_LAST) begin
          presc_d = '0;
          en_d    = 1'b1;
        end else begin
          presc_d = presc_q + TICK_W'(1);
        end
      end
      S_PAUSE: begin
        if (start) begin
          state_d  = S_LOAD;
          preset_d = preset_val;
          up_d     = mode_up;
        end else if (pause) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d  = S_LOAD;
          preset_d = preset_val;
          up_d     = mode_up;
        end
      end
      default: begin
        state_d = S_IDLE;
        presc_d = '0;
      end
    endcase
    if (clear) begin
      state_d = S_IDLE;
      presc_d = '0;
      en_d    = 1'b0;
    end
    rst_d      = (state_d == S_IDLE) || (state_d == S_LOAD);
    load_d     = (state_d == S_LOAD) && !up_d;
    load_val_d = load_d ? preset_d : '0;
    running_d  = (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
    alarm_d    = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // State, datapath and output registers; frozen until the release synchroniser fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      presc_q      <= '0;
      preset_q     <= '0;
      up_q         <= 1'b0;
      cnt_rst      <= 1'b1;
      cnt_load     <= 1'b0;
      cnt_load_val <= '0;
      cnt_en       <= 1'b0;
      running      <= 1'b0;
      done         <= 1'b0;
      alarm        <= 1'b0;
    end else if (run_en) begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      preset_q     <= preset_d;
      up_q         <= up_d;
      cnt_rst      <= rst_d;
      cnt_load     <= load_d;
      cnt_load_val <= load_val_d;
      cnt_en       <= en_d;
      running      <= running_d;
      done         <= done_d;
      alarm        <= alarm_d;
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: directed bench for timer_ctrl driving a behavioural 2-digit BCD chain.
module tb_timer_ctrl;

  localparam int unsigned ND = 2;
  localparam int unsigned VW = 4 * ND;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          pause = 1'b0;
  logic          clear = 1'b0;
  logic          mode_up = 1'b0;
  logic [VW-1:0] preset_val = '0;
  logic [VW-1:0] cnt_value = '0;
  logic          cnt_rst, cnt_load, cnt_en, cnt_up, running, done, alarm;
  logic [VW-1:0] cnt_load_val;
  logic [2:0]    state;

  int tests = 0;
  int fails = 0;
  int n_en, n_alarm, first_en, done_at, term_at, gap_bad, en_after, bad_bcd;

  timer_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(4), .TICK_W(2)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear),
    .mode_up(mode_up), .preset_val(preset_val), .cnt_value(cnt_value),
    .cnt_rst(cnt_rst), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
    .cnt_en(cnt_en), .cnt_up(cnt_up), .state(state), .running(running),
    .done(done), .alarm(alarm)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (r[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (r[7:4] == 4'd9) ? 4'd0 : r[7:4] + 4'd1;
    end else begin
      r[3:0] = r[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (r[3:0] == 4'd0) begin
      r[3:0] = 4'd9;
      r[7:4] = (r[7:4] == 4'd0) ? 4'd9 : r[7:4] - 4'd1;
    end else begin
      r[3:0] = r[3:0] - 4'd1;
    end
    return r;
  endfunction

  // Behavioural digit chain: clear/load on cnt_rst, count one edge after cnt_en.
  always @(posedge clk) begin
    if (cnt_rst)     cnt_value <= cnt_load ? cnt_load_val : '0;
    else if (cnt_en) cnt_value <= cnt_up ? bcd_inc(cnt_value) : bcd_dec(cnt_value);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] p, input logic up);
    preset_val = p;
    mode_up    = up;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Observe ncyc cycles (index 0 = current negedge) and collect run statistics.
  task automatic watch(input int ncyc, input logic [7:0] term);
    int last;
    last = -1; n_en = 0; n_alarm = 0; first_en = -1; done_at = -1;
    term_at = -1; gap_bad = 0; en_after = 0; bad_bcd = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (cnt_en === 1'b1) begin
        if (first_en < 0) first_en = i;
        if (last >= 0 && (i - last) != 4) gap_bad++;
        if (done_at >= 0) en_after++;
        last = i;
        n_en++;
      end
      if (alarm === 1'b1) n_alarm++;
      if (done === 1'b1 && done_at < 0) done_at = i;
      if (cnt_value === term && term_at < 0) term_at = i;
      if (cnt_value[3:0] > 4'd9 || cnt_value[7:4] > 4'd9) bad_bcd++;
      @(negedge clk);
    end
  endtask

  initial begin
    int pe;
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state",   32'(state), 32'd0);
    check("rst_cnt_rst", 32'(cnt_rst), 32'd1);
    check("rst_load",    32'(cnt_load), 32'd0);
    check("rst_en",      32'(cnt_en), 32'd0);
    check("rst_up",      32'(cnt_up), 32'd0);
    check("rst_flags",   32'({running, done, alarm}), 32'd0);
    check("rst_ldval",   32'(cnt_load_val), 32'd0);

    // Start coinciding with the first edge after release is not acted upon
    reset = 1'b1;
    start = 1'b1; preset_val = 8'h03; mode_up = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("sync_gate", 32'(state), 32'd0);
    repeat (2) @(negedge clk);
    check("idle_hold", 32'(state), 32'd0);

    // Count down from 03
    pulse_start(8'h03, 1'b0);
    check("t1_load_state", 32'(state), 32'd1);
    check("t1_load_ctl",   32'({cnt_rst, cnt_load, cnt_up}), 32'b110);
    check("t1_load_val",   32'(cnt_load_val), 32'h03);
    @(negedge clk);
    check("t1_run_state",  32'(state), 32'd2);
    check("t1_run_value",  32'(cnt_value), 32'h03);
    check("t1_running",    32'({running, cnt_rst}), 32'b10);
    watch(20, 8'h00);
    check("t1_first_en",   32'(first_en), 32'd4);
    check("t1_n_en",       32'(n_en), 32'd3);
    check("t1_gap",        32'(gap_bad), 32'd0);
    check("t1_zero_at",    32'(term_at), 32'd13);
    check("t1_done_at",    32'(done_at), 32'd14);
    check("t1_alarms",     32'(n_alarm), 32'd1);
    check("t1_end_state",  32'(state), 32'd4);

    // Count up to 12 through the 09 -> 10 wrap
    pulse_start(8'h12, 1'b1);
    check("t2_load_state", 32'(state), 32'd1);
    check("t2_load_ctl",   32'({cnt_rst, cnt_load, cnt_up}), 32'b101);
    check("t2_load_val",   32'(cnt_load_val), 32'h00);
    @(negedge clk);
    check("t2_run_value",  32'(cnt_value), 32'h00);
    watch(60, 8'h12);
    check("t2_n_en",       32'(n_en), 32'd12);
    check("t2_gap",        32'(gap_bad), 32'd0);
    check("t2_bcd",        32'(bad_bcd), 32'd0);
    check("t2_term_at",    32'(term_at), 32'd49);
    check("t2_done_at",    32'(done_at), 32'd50);
    check("t2_en_after",   32'(en_after), 32'd0);
    check("t2_final",      32'({done, cnt_value}), 32'h112);

    // Pause two cycles after a tick, then resume
    pulse_start(8'h05, 1'b0);
    @(negedge clk);
    check("t3_run_value",  32'(cnt_value), 32'h05);
    repeat (4) @(negedge clk);
    check("t3_tick",       32'(cnt_en), 32'd1);
    repeat (2) @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    check("t3_paused",     32'({state, cnt_en}), 32'({3'd3, 1'b0}));
    pe = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cnt_en !== 1'b0) pe++;
    end
    check("t3_pause_en",   32'(pe), 32'd0);
    check("t3_pause_hold", 32'({state, cnt_value}), 32'({3'd3, 8'h04}));
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    check("t3_resume",     32'({state, cnt_en}), 32'({3'd2, 1'b0}));
    @(negedge clk);
    check("t3_resume_c1",  32'(cnt_en), 32'd0);
    @(negedge clk);
    check("t3_resume_en",  32'(cnt_en), 32'd1);
    @(negedge clk);
    check("t3_value_03",   32'(cnt_value), 32'h03);

    // Start during PAUSE reloads with the new preset
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    check("t4_paused",     32'(state), 32'd3);
    pulse_start(8'h07, 1'b0);
    check("t4_load",       32'({state, cnt_load}), 32'({3'd1, 1'b1}));
    check("t4_load_val",   32'(cnt_load_val), 32'h07);
    @(negedge clk);
    check("t4_run_value",  32'({state, cnt_value}), 32'({3'd2, 8'h07}));

    // Clear beats start in the same cycle
    clear = 1'b1; start = 1'b1; preset_val = 8'h09; mode_up = 1'b0;
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    check("t5_idle",       32'({state, cnt_rst, cnt_load, running}), 32'({3'd0, 3'b100}));
    @(negedge clk);
    check("t5_cleared",    32'({state, cnt_value}), 32'({3'd0, 8'h00}));

    // Preset already at terminal value: done without any tick
    pulse_start(8'h00, 1'b0);
    check("t6_load",       32'({state, cnt_en}), 32'({3'd1, 1'b0}));
    @(negedge clk);
    check("t6_run",        32'({state, cnt_en, cnt_value}), 32'({3'd2, 1'b0, 8'h00}));
    @(negedge clk);
    check("t6_done",       32'({state, cnt_en, done, alarm}), 32'({3'd4, 3'b011}));
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    check("t6_pause_ign",  32'({state, done, alarm}), 32'({3'd4, 2'b10}));

    // Asynchronous reset in the middle of a run
    pulse_start(8'h20, 1'b1);
    repeat (3) @(negedge clk);
    check("t7_pre_rst",    32'({state, cnt_up}), 32'({3'd2, 1'b1}));
    #2 reset = 1'b0;
    #1;
    check("t7_rst_state",  32'(state), 32'd0);
    check("t7_rst_ctl",    32'({cnt_rst, cnt_load, cnt_en, cnt_up}), 32'b1000);
    check("t7_rst_flags",  32'({running, done, alarm}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("t7_idle_wait",  32'({state, cnt_value}), 32'({3'd0, 8'h00}));
    pulse_start(8'h02, 1'b1);
    check("t7_restart",    32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
